// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive path.
package uart_pkg;

    localparam logic [1:0] BAUD_7200   = 2'b00;
    localparam logic [1:0] BAUD_9600   = 2'b01;
    localparam logic [1:0] BAUD_19200  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    localparam int BAUD_RATES [0:3] = '{7200, 9600, 19200, 115200};

    localparam int DATA_W  = 8;
    localparam int FLAG_W  = 2;
    localparam int ENTRY_W = DATA_W + FLAG_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    // Frame settings captured at the start bit; handshake stays live and is not latched.
    typedef struct packed {
        logic [1:0] baud;
        logic       twoStop;
        logic [1:0] dataSel;
        logic       evenPar;
        logic       parEn;
    } frame_cfg_t;

    function automatic int baud_div(input int clkFreq, input int baud, input int os);
        return (clkFreq + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic logic [3:0] data_bits(input logic [1:0] sel);
        return 4'(sel) + 4'd5;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a pop on full lets a push through.
module uart_rx_fifo
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_headData,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count    = r_count;
    assign o_headData = r_mem[r_rdPtr];

    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled mid-bit sampling FSM feeding a receive FIFO
// with per-entry error flags, sticky overrun and occupancy-driven RTS.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_MARGIN = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_controls,
    input  logic                          i_rx,
    input  logic                          i_rd_en,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_rts
);

    localparam int DIV0   = baud_div(CLK_FREQ, BAUD_RATES[0], OVERSAMPLE);
    localparam int DIV1   = baud_div(CLK_FREQ, BAUD_RATES[1], OVERSAMPLE);
    localparam int DIV2   = baud_div(CLK_FREQ, BAUD_RATES[2], OVERSAMPLE);
    localparam int DIV3   = baud_div(CLK_FREQ, BAUD_RATES[3], OVERSAMPLE);
    localparam int TICK_W = $clog2(DIV0 + 1);
    localparam int OS_W   = $clog2(OVERSAMPLE);
    localparam int HALF   = OVERSAMPLE / 2;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    rx_state_t        r_state;
    frame_cfg_t       r_cfg;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rxPrev;
    logic [TICK_W-1:0] r_tickCnt;
    logic [OS_W-1:0]  r_osCnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             r_parityErr;
    logic             r_frameErr;
    logic             r_overrun;
    logic             r_rts;

    logic [TICK_W-1:0] w_divMinus1;
    logic [OS_W-1:0]  w_sampleTarget;
    logic [2:0]       w_lastBit;
    logic             w_tick;
    logic             w_startFrame;
    logic             w_sampleNow;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0] w_free;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= i_rx;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end

    always_comb begin
        w_divMinus1 = TICK_W'(DIV0 - 1);
        case (r_cfg.baud)
            BAUD_7200:   w_divMinus1 = TICK_W'(DIV0 - 1);
            BAUD_9600:   w_divMinus1 = TICK_W'(DIV1 - 1);
            BAUD_19200:  w_divMinus1 = TICK_W'(DIV2 - 1);
            BAUD_115200: w_divMinus1 = TICK_W'(DIV3 - 1);
            default:     w_divMinus1 = TICK_W'(DIV0 - 1);
        endcase
    end

    assign w_startFrame   = (r_state == ST_IDLE) && r_rxPrev && !r_sync2;
    assign w_tick         = (r_tickCnt == w_divMinus1);
    assign w_sampleTarget = (r_state == ST_START) ? OS_W'(HALF - 1) : OS_W'(OVERSAMPLE - 1);
    assign w_sampleNow    = w_tick && (r_state != ST_IDLE) && (r_osCnt == w_sampleTarget);
    assign w_lastBit      = 3'(data_bits(r_cfg.dataSel) - 4'd1);

    // Reloading on the start edge phase-aligns every later sample to the falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_startFrame || w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_osCnt     <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            if (w_tick && (r_state != ST_IDLE)) begin
                r_osCnt <= w_sampleNow ? '0 : r_osCnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_startFrame) begin
                        r_cfg       <= {i_controls[7:5], i_controls[3:0]};
                        r_osCnt     <= '0;
                        r_bitIdx    <= '0;
                        r_shift     <= '0;
                        r_parityErr <= 1'b0;
                        r_frameErr  <= 1'b0;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_sampleNow) begin
                        r_state <= r_sync2 ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_sampleNow) begin
                        r_shift[r_bitIdx] <= r_sync2;
                        if (r_bitIdx == w_lastBit) begin
                            r_state <= r_cfg.parEn ? ST_PARITY : ST_STOP1;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_sampleNow) begin
                        r_parityErr <= (^r_shift) ^ r_sync2 ^ !r_cfg.evenPar;
                        r_state     <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (w_sampleNow) begin
                        r_frameErr <= !r_sync2;
                        r_state    <= r_cfg.twoStop ? ST_STOP2 : ST_IDLE;
                    end
                end
                ST_STOP2: begin
                    if (w_sampleNow) begin
                        r_frameErr <= r_frameErr | !r_sync2;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The last stop sample is folded straight into the pushed entry.
    assign w_push  = w_sampleNow && (((r_state == ST_STOP1) && !r_cfg.twoStop) || (r_state == ST_STOP2));
    assign w_entry = {r_frameErr | !r_sync2, r_parityErr, r_shift};
    assign w_pop   = i_rd_en && !w_empty;
    assign w_drop  = w_push && w_full && !w_pop;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_pushData (w_entry),
        .i_pop      (w_pop),
        .o_headData (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (o_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (w_pop) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_free = CNT_W'(FIFO_DEPTH) - o_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_controls[4]) begin
            r_rts <= 1'b1;
        end else begin
            r_rts <= (int'(w_free) > RTS_MARGIN);
        end
    end

    assign o_valid      = !w_empty;
    assign o_data       = o_valid ? w_head[7:0] : 8'h00;
    assign o_parity_err = o_valid && w_head[8];
    assign o_frame_err  = o_valid && w_head[9];
    assign o_overrun    = r_overrun;
    assign o_rts        = r_rts;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine; the reduced clock gives divisors 32/24/12/2
// so that 115200 bits last 32 clocks, 19200 bits 192 and 9600 bits 384.
module tb_uart_rx_engine;

    localparam int CLK_FREQ    = 3686400;
    localparam int DEPTH       = 8;
    localparam int BIT_FAST    = 32;
    localparam int BIT_19200   = 192;
    localparam int BIT_9600    = 384;
    localparam int PUSH_OFFSET = 306;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] controls;
    logic       rx;
    logic       rd_en;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic [3:0] count;
    logic       rts;

    int passCount  = 0;
    int checkCount = 0;
    logic [7:0] expQ [$];

    always #10 clk = ~clk;

    uart_rx_engine #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (DEPTH),
        .RTS_MARGIN (1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_controls   (controls),
        .i_rx         (rx),
        .i_rd_en      (rd_en),
        .o_data       (data),
        .o_valid      (valid),
        .o_parity_err (parity_err),
        .o_frame_err  (frame_err),
        .o_overrun    (overrun),
        .o_count      (count),
        .o_rts        (rts)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Drives one serial frame, each bit held for bitCyc clocks, starting at the next negedge.
    task automatic applyStimulus(input logic [7:0] dataByte, input int nBits, input logic parEn,
                                 input logic parBit, input logic stop1, input logic twoStop,
                                 input logic stop2, input int bitCyc);
        @(negedge clk);
        rx = 1'b0;
        repeat (bitCyc) @(negedge clk);
        for (int b = 0; b < nBits; b++) begin
            rx = dataByte[b];
            repeat (bitCyc) @(negedge clk);
        end
        if (parEn) begin
            rx = parBit;
            repeat (bitCyc) @(negedge clk);
        end
        rx = stop1;
        repeat (bitCyc) @(negedge clk);
        if (twoStop) begin
            rx = stop2;
            repeat (bitCyc) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rd_en    = 1'b0;
        controls = 8'hCC;
        repeat (4) @(negedge clk);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset data", data, 0);
        checkOutput("reset count", count, 0);
        checkOutput("reset rts", rts, 1);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset parity_err", parity_err, 0);
        checkOutput("reset frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 at 115200
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT_FAST);
        repeat (4) @(negedge clk);
        checkOutput("8N1 valid", valid, 1);
        checkOutput("8N1 data", data, 8'hA5);
        checkOutput("8N1 parity_err", parity_err, 0);
        checkOutput("8N1 frame_err", frame_err, 0);
        checkOutput("8N1 count", count, 1);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        checkOutput("8N1 pop valid", valid, 0);
        checkOutput("8N1 pop count", count, 0);

        // 9600, 5 bits, even parity; 0x13 has three ones so the correct parity bit is 1
        controls = 8'h43;
        applyStimulus(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BIT_9600);
        repeat (4) @(negedge clk);
        checkOutput("parity valid", valid, 1);
        checkOutput("parity data", data, 8'h13);
        checkOutput("parity parity_err", parity_err, 1);
        checkOutput("parity frame_err", frame_err, 0);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;

        // two stop bits, second one low
        controls = 8'hEC;
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BIT_FAST);
        repeat (4) @(negedge clk);
        checkOutput("stop2 valid", valid, 1);
        checkOutput("stop2 data", data, 8'h3C);
        checkOutput("stop2 frame_err", frame_err, 1);
        checkOutput("stop2 parity_err", parity_err, 0);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;

        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_FAST / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_FAST) @(negedge clk);
        checkOutput("glitch valid", valid, 0);
        checkOutput("glitch count", count, 0);
        applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, BIT_FAST);
        repeat (4) @(negedge clk);
        checkOutput("post-glitch data", data, 8'h5A);
        checkOutput("post-glitch frame_err", frame_err, 0);
        checkOutput("post-glitch count", count, 1);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;

        // handshake on: fill past capacity
        controls = 8'hDC;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT_FAST);
            if (expQ.size() < DEPTH) expQ.push_back(8'(8'h10 + i));
            repeat (4) @(negedge clk);
            if (i == 5) begin
                checkOutput("fill6 count", count, 6);
                checkOutput("fill6 rts", rts, 1);
            end
            if (i == 6) begin
                checkOutput("fill7 count", count, 7);
                checkOutput("fill7 rts", rts, 0);
            end
        end
        checkOutput("full count", count, 8);
        checkOutput("full overrun", overrun, 1);
        checkOutput("full head", data, expQ[0]);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        void'(expQ.pop_front());
        checkOutput("overrun cleared", overrun, 0);
        checkOutput("after pop count", count, 7);
        checkOutput("after pop head", data, expQ[0]);

        applyStimulus(8'h20, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT_FAST);
        expQ.push_back(8'h20);
        repeat (4) @(negedge clk);
        checkOutput("refill count", count, 8);

        // pop exactly in the push cycle while full
        for (int i = 0; i < 12; i++) begin
            fork
                applyStimulus(8'(8'h30 + i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT_FAST);
                begin
                    @(negedge clk);
                    repeat (PUSH_OFFSET) @(negedge clk);
                    checkOutput("simul head", data, expQ[0]);
                    rd_en = 1'b1;
                    @(negedge clk);
                    rd_en = 1'b0;
                end
            join
            void'(expQ.pop_front());
            expQ.push_back(8'(8'h30 + i));
            repeat (4) @(negedge clk);
            checkOutput("simul count", count, 8);
            checkOutput("simul overrun", overrun, 0);
        end

        for (int k = 0; k < DEPTH; k++) begin
            checkOutput("drain valid", valid, 1);
            checkOutput("drain data", data, expQ[0]);
            rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
            void'(expQ.pop_front());
        end
        @(negedge clk);
        checkOutput("drained valid", valid, 0);
        checkOutput("drained count", count, 0);
        checkOutput("drained rts", rts, 1);

        // reset during DATA, then switch to 19200
        applyStimulus(8'h42, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT_FAST);
        repeat (4) @(negedge clk);
        checkOutput("pre-reset count", count, 1);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_FAST) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_FAST) @(negedge clk);
        rx = 1'b0;
        repeat (BIT_FAST / 2) @(negedge clk);
        rst      = 1'b1;
        rx       = 1'b1;
        controls = 8'h8C;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("midreset valid", valid, 0);
        checkOutput("midreset count", count, 0);
        checkOutput("midreset rts", rts, 1);
        applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT_19200);
        repeat (4) @(negedge clk);
        checkOutput("19200 valid", valid, 1);
        checkOutput("19200 data", data, 8'hC3);
        checkOutput("19200 parity_err", parity_err, 0);
        checkOutput("19200 frame_err", frame_err, 0);
        checkOutput("19200 count", count, 1);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        checkOutput("19200 pop valid", valid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised, single-clock UART receive engine. Successor to the per-baud derived-clock receiver: one shared clock with a clock-enable oversampling tick, mid-bit sampling, latched frame configuration, an internal receive FIFO with per-entry error flags, and RTS flow control driven from FIFO occupancy. Sits between the board rx pin and the consumer logic.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
OVERSAMPLE, 16, ticks per bit; even, at least 8
FIFO_DEPTH, 8, receive FIFO entries; power of 2, at least 2
RTS_MARGIN, 1, free entries at or below which rts deasserts

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
controls  in  8  [7:6] baud 00=7200 01=9600 10=19200 11=115200; [5] stop bits 0=1 1=2; [4] handshake enable; [3:2] data bits 00=5 01=6 10=7 11=8; [1] 1=even 0=odd parity; [0] parity enable
rx  in  1  serial input, idle high, asynchronous
rd_en  in  1  pop FIFO head; ignored when valid=0
data  out  8  FIFO head byte, LSB-aligned, unused upper bits 0
valid  out  1  FIFO non-empty
parity_err  out  1  parity error flag of head entry
frame_err  out  1  stop-bit error flag of head entry
overrun  out  1  sticky: a frame arrived while the FIFO was full
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
rts  out  1  1 = ready to receive

Behaviour:
- Reset: all outputs 0 except rts=1; FSM IDLE; FIFO empty; synchroniser flops set to 1. Reset mid-frame aborts the frame and nothing is pushed.
- rx passes through a 2-flop synchroniser. All timing below refers to the synchronised rx.
- Tick generator: modulo counter with divisor DIV[sel] = round(CLK_FREQ/(baud*OVERSAMPLE)). It produces a 1-cycle tick. The counter reloads whenever the FSM enters START, so the tick phase aligns to the falling edge.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on a falling edge (1 to 0), latch controls into a frame config register and go to START. Changes to controls mid-frame have no effect.
  - START: after OVERSAMPLE/2 ticks, sample rx. If rx=0, go to DATA. If rx=1, treat as a glitch and return to IDLE with no push.
  - DATA: sample every OVERSAMPLE ticks, LSB first, shifting N bits (N = 5..8). Then go to PARITY if parity is enabled, else STOP1.
  - PARITY: one sample. parity_err = (XOR of data bits XOR sample) != (even ? 0 : 1).
  - STOP1: one sample; rx=0 sets frame_err. Go to STOP2 if two stop bits are configured, else push.
  - STOP2: one sample; rx=0 sets frame_err. Then push.
- Push happens in the same cycle as the last stop sample; the FSM returns to IDLE on the next clk.
- Errored frames are still pushed, with their flags stored in the entry.
- FIFO entry = {frame_err, parity_err, data[7:0]}. Show-ahead: data, parity_err and frame_err reflect the head combinationally from registered storage.
  - valid=1 and rd_en=1: head advances at the next edge.
  - Push on full: the frame is dropped and overrun is set. Exception: a simultaneous pop on full frees space, so the push is accepted and overrun stays 0.
  - overrun is cleared by the first accepted rd_en after it is set, or by rst.
  - count updates on the edge after each push/pop; a simultaneous push and pop leaves count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- rts is registered:
  - If handshake is disabled (live controls[4]), rts=1.
  - Otherwise rts = (FIFO_DEPTH - count) > RTS_MARGIN, updated one cycle after count changes.

Decomposition:
- Package uart_pkg holds:
  - baud select encodings and the baud rate constant array;
  - function baud_div(clk_freq, baud, os);
  - data-bits decode (sel+5);
  - FSM state enum;
  - FIFO entry field widths.
- One natural sub-module: uart_rx_fifo, a parametrised show-ahead synchronous FIFO with count output.
- The tick generator and FSM stay in uart_rx_engine.

Test Plan:
- Defaults, controls=8'hCC (115200, 8N1, DIV=27): send 0xA5 → valid=1 with data=8'hA5, flags=0, count=1; rd_en for 1 cycle → valid=0, count=0.
- controls=8'h43 (9600, 5 bits, even parity, DIV=326): send 0x13 with a wrong parity bit → data=8'h13, parity_err=1, frame_err=0.
- controls=8'hEC (115200, 8 bits, 2 stop bits): second stop bit driven 0 → frame_err=1, entry still pushed. A 0.25-bit low pulse on idle rx → no push, FSM returns to IDLE.
- FIFO_DEPTH=8, handshake on (controls=8'hDC): push 7 bytes → rts=0 after the 7th. Push 9 with no reads → count=8, overrun=1, the 9th byte is lost. One rd_en → overrun=0, count=7.
- Simultaneous push and pop while full → count stays 8, overrun stays 0, order preserved across pointer wrap (check 20 bytes in sequence).
- Assert rst during DATA of a frame, then change controls to 8'h8C → FIFO empty, rts=1, the next frame is received correctly at 19200.
